serdes_rst_ctrl: RTL and testbench

SERDES_RST_CTRL -- requirements
Module: serdes_rst_ctrl

---
 rtl/serdes_rst_ctrl.sv | 150 +++++++++++++++
 tb/tb_serdes_rst_ctrl.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/serdes_rst_ctrl.sv
// serdes_rst_ctrl: transceiver reset sequencer.
// Drives PLL / TX / RX resets in order, waits for each lock/done status,
// retries on timeout and parks in FAIL after MAX_RETRY timeouts.
module serdes_rst_ctrl #(
  parameter int unsigned PLL_RST_CYC = 16,
  parameter int unsigned TIMEOUT     = 1000,
  parameter int unsigned MAX_RETRY   = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       soft_rst,
  input  logic       pll_lock,
  input  logic       tx_rst_done,
  input  logic       rx_cdr_lock,
  input  logic       rx_rst_done,
  output logic       pll_rst,
  output logic       tx_rst,
  output logic       rx_rst,
  output logic       link_ready,
  output logic       fail,
  output logic [3:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_PLL_RST  = 3'd0,
    ST_WAIT_PLL = 3'd1,
    ST_WAIT_TX  = 3'd2,
    ST_WAIT_RX  = 3'd3,
    ST_READY    = 3'd4,
    ST_FAIL     = 3'd5
  } state_e;

  localparam logic [15:0] PLL_LAST = 16'(PLL_RST_CYC - 1);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);
  localparam logic [3:0]  RETRY_MAX = 4'(MAX_RETRY);

  // Raw status inputs packed so one synchronizer loop covers all of them.
  logic [3:0] async_in;
  logic [3:0] meta_reg;
  logic [3:0] sync_reg;

  assign async_in = {rx_rst_done, rx_cdr_lock, tx_rst_done, pll_lock};

  genvar gi;
  generate
    for (gi = 0; gi < 4; gi++) begin : g_sync
      // Two-flop synchronizer for one asynchronous status bit.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          meta_reg[gi] <= 1'b0;
          sync_reg[gi] <= 1'b0;
        end else begin
          meta_reg[gi] <= async_in[gi];
          sync_reg[gi] <= meta_reg[gi];
        end
      end
    end
  endgenerate

  logic pll_lock_s, tx_done_s, cdr_lock_s, rx_done_s;
  assign pll_lock_s = sync_reg[0];
  assign tx_done_s  = sync_reg[1];
  assign cdr_lock_s = sync_reg[2];
  assign rx_done_s  = sync_reg[3];

  state_e      state_reg, state_next;
  logic [15:0] timer_reg, timer_next;
  logic [3:0]  retry_reg, retry_next;
  logic [3:0]  retry_inc;
  logic        timeout_hit;

  assign retry_inc = (retry_reg == 4'd15) ? 4'd15 : retry_reg + 4'd1;

  // Next-state, retry and timer computation; soft_rst overrides everything.
  always_comb begin
    state_next  = state_reg;
    retry_next  = retry_reg;
    timeout_hit = 1'b0;
    if (soft_rst) begin
      state_next = ST_PLL_RST;
      retry_next = 4'd0;
    end else begin
      case (state_reg)
        ST_PLL_RST: begin
          if (timer_reg == PLL_LAST) state_next = ST_WAIT_PLL;
        end
        ST_WAIT_PLL: begin
          if (pll_lock_s)                  state_next  = ST_WAIT_TX;
          else if (timer_reg == TMO_LAST)  timeout_hit = 1'b1;
        end
        ST_WAIT_TX: begin
          if (tx_done_s)                   state_next  = ST_WAIT_RX;
          else if (timer_reg == TMO_LAST)  timeout_hit = 1'b1;
        end
        ST_WAIT_RX: begin
          if (cdr_lock_s && rx_done_s)     state_next  = ST_READY;
          else if (timer_reg == TMO_LAST)  timeout_hit = 1'b1;
        end
        ST_READY: begin
          if (!pll_lock_s)                 state_next = ST_PLL_RST;
          else if (!cdr_lock_s)            state_next = ST_WAIT_RX;
        end
        ST_FAIL: state_next = ST_FAIL;
        default: state_next = ST_PLL_RST;
      endcase
      // Exit condition already had priority above, so this is a true timeout.
      if (timeout_hit) begin
        retry_next = retry_inc;
        state_next = (retry_inc == RETRY_MAX) ? ST_FAIL : ST_PLL_RST;
      end
    end
    // Timer restarts on every state entry (soft_rst counts as re-entry).
    if (soft_rst || (state_next != state_reg))
      timer_next = 16'd0;
    else if (timer_reg != 16'hFFFF)
      timer_next = timer_reg + 16'd1;
    else
      timer_next = timer_reg;
  end

  // State, counters and outputs; outputs are decoded from the next state so
  // they change on the same edge as the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_PLL_RST;
      timer_reg  <= 16'd0;
      retry_reg  <= 4'd0;
      pll_rst    <= 1'b1;
      tx_rst     <= 1'b1;
      rx_rst     <= 1'b1;
      link_ready <= 1'b0;
      fail       <= 1'b0;
    end else begin
      state_reg  <= state_next;
      timer_reg  <= timer_next;
      retry_reg  <= retry_next;
      pll_rst    <= (state_next == ST_PLL_RST) || (state_next == ST_FAIL);
      tx_rst     <= (state_next == ST_PLL_RST) || (state_next == ST_WAIT_PLL) ||
                    (state_next == ST_FAIL);
      rx_rst     <= (state_next != ST_WAIT_RX) && (state_next != ST_READY);
      link_ready <= (state_next == ST_READY);
      fail       <= (state_next == ST_FAIL);
    end
  end

  assign state     = state_reg;
  assign retry_cnt = retry_reg;

endmodule

// File: tb/tb_serdes_rst_ctrl.sv
// Testbench for serdes_rst_ctrl: directed scenarios plus randomized inputs,
// every cycle compared against a behavioural model of the sequencer rules.
module tb_serdes_rst_ctrl;

  localparam int PLL_RST_CYC = 16;
  localparam int TIMEOUT     = 1000;
  localparam int MAX_RETRY   = 3;

  logic       clk = 1'b0;
  logic       rst_n, soft_rst;
  logic       pll_lock, tx_rst_done, rx_cdr_lock, rx_rst_done;
  logic       pll_rst, tx_rst, rx_rst, link_ready, fail;
  logic [3:0] retry_cnt;
  logic [2:0] state;

  int n_pass  = 0;
  int n_total = 0;

  always #5 clk = ~clk;

  serdes_rst_ctrl #(
    .PLL_RST_CYC (PLL_RST_CYC),
    .TIMEOUT     (TIMEOUT),
    .MAX_RETRY   (MAX_RETRY)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .soft_rst    (soft_rst),
    .pll_lock    (pll_lock),
    .tx_rst_done (tx_rst_done),
    .rx_cdr_lock (rx_cdr_lock),
    .rx_rst_done (rx_rst_done),
    .pll_rst     (pll_rst),
    .tx_rst      (tx_rst),
    .rx_rst      (rx_rst),
    .link_ready  (link_ready),
    .fail        (fail),
    .retry_cnt   (retry_cnt),
    .state       (state)
  );

  // Reference model. Status inputs are seen by the sequencer two cycles late
  // (dly1 -> dly2); states are numbered 0..5 as listed in the requirements.
  int       m_state, m_timer, m_retry;
  int       m_nx, m_nr;
  logic     m_ok;
  logic [3:0] dly1, dly2;   // {rx_rst_done, rx_cdr_lock, tx_rst_done, pll_lock}

  always_comb begin
    m_nx = m_state;
    m_nr = m_retry;
    m_ok = 1'b0;
    if (soft_rst) begin
      m_nx = 0;
      m_nr = 0;
    end else if (m_state == 0) begin
      if (m_timer == PLL_RST_CYC - 1) m_nx = 1;
    end else if (m_state >= 1 && m_state <= 3) begin
      if (m_state == 1)      m_ok = dly2[0];
      else if (m_state == 2) m_ok = dly2[1];
      else                   m_ok = dly2[2] & dly2[3];
      if (m_ok) m_nx = m_state + 1;
      else if (m_timer == TIMEOUT - 1) begin
        m_nr = (m_retry < 15) ? m_retry + 1 : 15;
        m_nx = (m_nr == MAX_RETRY) ? 5 : 0;
      end
    end else if (m_state == 4) begin
      if (!dly2[0])      m_nx = 0;
      else if (!dly2[2]) m_nx = 3;
    end else if (m_state != 5) begin
      m_nx = 0;
    end
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_state <= 0;
      m_timer <= 0;
      m_retry <= 0;
      dly1    <= '0;
      dly2    <= '0;
    end else begin
      m_state <= m_nx;
      m_retry <= m_nr;
      m_timer <= (soft_rst || m_nx != m_state) ? 0 :
                 ((m_timer < 65535) ? m_timer + 1 : m_timer);
      dly1    <= {rx_rst_done, rx_cdr_lock, tx_rst_done, pll_lock};
      dly2    <= dly1;
    end
  end

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic check_all();
    chk("state",      16'(state),      16'(m_state));
    chk("retry_cnt",  16'(retry_cnt),  16'(m_retry));
    chk("pll_rst",    16'(pll_rst),    16'(m_state == 0 || m_state == 5));
    chk("tx_rst",     16'(tx_rst),     16'(m_state == 0 || m_state == 1 || m_state == 5));
    chk("rx_rst",     16'(rx_rst),     16'(m_state != 3 && m_state != 4));
    chk("link_ready", 16'(link_ready), 16'(m_state == 4));
    chk("fail",       16'(fail),       16'(m_state == 5));
  endtask

  // One clock cycle; outputs sampled on the falling edge.
  task automatic step();
    @(negedge clk);
    check_all();
  endtask

  function automatic logic out_sel(input int sel);
    case (sel)
      0:       return pll_rst;
      1:       return tx_rst;
      2:       return rx_rst;
      3:       return link_ready;
      default: return fail;
    endcase
  endfunction

  // Count cycles until the selected output reaches val (bounded).
  task automatic measure(input string tag, input int sel, input logic val, input int exp);
    int n;
    n = 0;
    do begin
      step();
      n++;
    end while (out_sel(sel) !== val && n < 5000);
    chk(tag, 16'(n), 16'(exp));
  endtask

  task automatic pulse_soft();
    soft_rst = 1'b1;
    step();
    soft_rst = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; soft_rst = 1'b0;
    pll_lock = 1'b0; tx_rst_done = 1'b0; rx_cdr_lock = 1'b0; rx_rst_done = 1'b0;
    step(); step();
    chk("rst_state",   16'(state),      16'd0);
    chk("rst_pll_rst", 16'(pll_rst),    16'd1);
    chk("rst_tx_rst",  16'(tx_rst),     16'd1);
    chk("rst_rx_rst",  16'(rx_rst),     16'd1);
    chk("rst_link",    16'(link_ready), 16'd0);
    chk("rst_retry",   16'(retry_cnt),  16'd0);
    rst_n = 1'b1;

    // Nominal bring-up, each status rising as its reset is released.
    measure("nom_pll_rst_fall", 0, 1'b0, 16);
    pll_lock = 1'b1;
    measure("nom_tx_rst_fall", 1, 1'b0, 3);
    tx_rst_done = 1'b1;
    measure("nom_rx_rst_fall", 2, 1'b0, 3);
    rx_cdr_lock = 1'b1; rx_rst_done = 1'b1;
    measure("nom_link_up", 3, 1'b1, 3);
    chk("nom_retry", 16'(retry_cnt), 16'd0);

    // CDR loss in READY falls back to WAIT_RX only.
    rx_cdr_lock = 1'b0;
    measure("cdr_link_drop", 3, 1'b0, 3);
    chk("cdr_state", 16'(state), 16'd3);
    rx_cdr_lock = 1'b1;
    measure("cdr_relink", 3, 1'b1, 3);

    // PLL lock lost for 4 cycles in READY: full re-run, retry unchanged.
    pll_lock = 1'b0;
    measure("pll_link_drop", 3, 1'b0, 3);
    chk("pll_drop_state", 16'(state), 16'd0);
    step();
    pll_lock = 1'b1;
    measure("pll_rerun_link", 3, 1'b1, 18);
    chk("pll_drop_retry", 16'(retry_cnt), 16'd0);

    // rx_rst_done arrives exactly on the last WAIT_RX cycle: exit wins.
    rx_rst_done = 1'b0;
    pulse_soft();
    measure("late_rx_enter", 2, 1'b0, 18);
    repeat (997) step();
    rx_rst_done = 1'b1;
    measure("late_rx_link", 3, 1'b1, 3);
    chk("late_rx_retry", 16'(retry_cnt), 16'd0);

    // PLL never locks: three timeouts then FAIL.
    pll_lock = 1'b0;
    pulse_soft();
    measure("fail_rise", 4, 1'b1, 3048);
    chk("fail_state",   16'(state),     16'd5);
    chk("fail_retry",   16'(retry_cnt), 16'd3);
    chk("fail_pll_rst", 16'(pll_rst),   16'd1);
    repeat (20) step();
    chk("fail_persist", 16'(state), 16'd5);

    // soft_rst from FAIL, then soft_rst coinciding with a timeout.
    pulse_soft();
    chk("soft_fail_state", 16'(state),     16'd0);
    chk("soft_fail_retry", 16'(retry_cnt), 16'd0);
    repeat (1015) step();
    pulse_soft();
    chk("soft_tmo_state", 16'(state),     16'd0);
    chk("soft_tmo_retry", 16'(retry_cnt), 16'd0);

    // One-cycle rst_n pulse in WAIT_TX restarts everything.
    pll_lock = 1'b1; tx_rst_done = 1'b0;
    pulse_soft();
    measure("to_wait_tx", 1, 1'b0, 17);
    repeat (5) step();
    rst_n = 1'b0;
    #1;
    chk("async_pll_rst", 16'(pll_rst), 16'd1);
    chk("async_tx_rst",  16'(tx_rst),  16'd1);
    chk("async_rx_rst",  16'(rx_rst),  16'd1);
    chk("async_state",   16'(state),   16'd0);
    tx_rst_done = 1'b1;
    step();
    rst_n = 1'b1;
    measure("restart_pll_fall", 0, 1'b0, 16);
    measure("restart_tx_fall",  1, 1'b0, 1);
    measure("restart_rx_fall",  2, 1'b0, 1);
    measure("restart_link",     3, 1'b1, 1);

    // Randomized inputs, checked every cycle against the model.
    for (int i = 0; i < 4000; i++) begin
      pll_lock    = ($urandom_range(0, 39) != 0);
      tx_rst_done = ($urandom_range(0, 9)  != 0);
      rx_cdr_lock = ($urandom_range(0, 19) != 0);
      rx_rst_done = ($urandom_range(0, 7)  != 0);
      soft_rst    = ($urandom_range(0, 149) == 0);
      rst_n       = ($urandom_range(0, 999) != 0);
      step();
    end
    rst_n = 1'b1; soft_rst = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
